tdc_therm_encoder: RTL and testbench
====================================

TDC_THERM_ENCODER -- requirements
Module: tdc_therm_encoder

Interface
REQ-001 Parameter STAGES, default 40: number of 4-tap delay blocks; the thermometer is TAPS = 4*STAGES bits wide.
REQ-002 Parameter COARSE_W, default 16: width of the coarse cycle counter.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two: number of output timestamp slots.
REQ-004 Parameter FINE_W, derived as clog2(TAPS+1): fine code width; 8 at the default.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 therm_in  in  TAPS  latched thermometer; bit 4*j+k = tap k of block j; bit 0 is nearest the trigger.
REQ-008 hit  in  1  one-cycle strobe: therm_in is stable and holds a new sample this cycle.
REQ-009 ts_ready  in  1  downstream accepts the head timestamp.
REQ-010 clr_ovf  in  1  clears the sticky overflow flag.
REQ-011 ts_valid  out  1  the head timestamp is valid.
REQ-012 ts_data  out  COARSE_W+FINE_W  timestamp, coarse in the MSBs and fine in the LSBs.
REQ-013 ts_flag  out  1  head timestamp has a saturated fine code (0 or TAPS).
REQ-014 overflow  out  1  sticky: a timestamp was dropped.
REQ-015 fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 The coarse counter increments every clk and wraps from 2^COARSE_W-1 to 0.
REQ-017 Stage 1, hit cycle N: register therm_in and the coarse counter value of cycle N.
REQ-018 Stage 2, cycle N+1: apply the optional bubble filter (REQ-031) to the stage-1 thermometer.
REQ-019 Stage 3, cycle N+2: fine = population count of the filtered thermometer, range 0..TAPS.
REQ-020 Stage 3: ts_flag_int = 1 when fine==0 or fine==TAPS.
REQ-021 Stage 3: push {coarse, fine, ts_flag_int} into the FIFO at the end of cycle N+2.
REQ-022 If the FIFO was empty, ts_valid rises in cycle N+3; total latency from hit to ts_valid is 3 clk.
REQ-023 The pipeline is fully pipelined: a hit on every consecutive cycle produces one push per cycle.
REQ-024 Each pipeline stage carries its own valid bit; no push occurs without a preceding hit.
REQ-025 Handshake: a pop occurs when ts_valid && ts_ready; ts_data and ts_flag stay stable while ts_valid && !ts_ready.
REQ-026 FIFO full and a push with no pop in the same cycle: the push is dropped and overflow is set to 1.
REQ-027 FIFO full and a push with a pop in the same cycle: both occur, level is unchanged, overflow is unaffected.
REQ-028 FIFO empty and a push in the same cycle: no bypass; the data appears the next cycle.
REQ-029 clr_ovf and a new drop in the same cycle: overflow stays 1 (set wins).
REQ-030 ts_valid = (fifo_level != 0); the pointers wrap modulo FIFO_DEPTH.

Configuration
REQ-031 Macro TDC_BUBBLE_FILTER_EN defined: filtered bit i = majority(bit i-1, bit i, bit i+1); out-of-range neighbours are bit 0 -> 1 and bit TAPS-1 -> 0; stage 2 still costs one cycle.
REQ-032 TDC_BUBBLE_FILTER_EN undefined: stage 2 is a plain register of the raw thermometer; latency is identical.

Reset
REQ-033 While reset is low: coarse counter = 0, all stage valid bits = 0, FIFO pointers = 0, fifo_level = 0, ts_valid = 0, ts_data = 0, ts_flag = 0, overflow = 0.
REQ-034 Reset asserted mid-operation discards in-flight samples and FIFO contents immediately.
REQ-035 The first hit accepted is the one in the first cycle after reset deasserts.

Structure
REQ-036 Shared package tdc_pkg holds the TAPS and FINE_W derivation function, the timestamp struct typedef {coarse, fine, flag}, and the popcount function.
REQ-037 One sub-module, tdc_ts_fifo, implements the FIFO (push/pop, level, full/empty); the encoding pipeline stays in the top module.

Verification
REQ-038 Reset release, coarse=0; hit at cycle 10 with therm_in lower 37 bits set -> ts_valid at cycle 13, ts_data = {16'd10, 8'd37}, ts_flag = 0.
REQ-039 Filter enabled, therm_in = lower 50 ones with bit 20 cleared -> fine = 50; filter disabled -> fine = 49.
REQ-040 therm_in all zero -> fine = 0, ts_flag = 1; therm_in all ones -> fine = 160, ts_flag = 1.
REQ-041 ts_ready = 0 and 6 consecutive hits -> fifo_level = 4, overflow = 1, first 4 timestamps retained in order; clr_ovf -> overflow = 0.
REQ-042 FIFO full, ts_ready = 1 and a push in the same cycle -> level stays 4, overflow stays 0; coarse wrap from 65535 to 0 appears correctly in consecutive timestamps.
REQ-043 reset pulsed low 1 cycle after a hit -> no ts_valid follows, and all outputs are 0.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared TDC types and helpers: tap/fine-width derivation, timestamp record, popcount.
package tdc_pkg;

   localparam int MAX_TAPS = 1024;

   function automatic int taps_of(input int stages);
      return 4 * stages;
   endfunction

   function automatic int fine_w(input int taps);
      return $clog2(taps + 1);
   endfunction

   localparam int STAGES_DEF   = 40;
   localparam int COARSE_W_DEF = 16;
   localparam int TAPS_DEF     = taps_of(STAGES_DEF);
   localparam int FINE_W_DEF   = fine_w(TAPS_DEF);

   typedef struct packed {
      logic [COARSE_W_DEF-1:0] coarse;
      logic [FINE_W_DEF-1:0]   fine;
      logic                    flag;
   } ts_t;

   // Narrower thermometers are zero-extended by the caller.
   function automatic int popcount(input logic [MAX_TAPS-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < MAX_TAPS; i++) c = c + 32'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/tdc_therm_encoder_if.sv
// Sample-in / timestamp-out handshake bundle of the thermometer encoder.
interface tdc_therm_encoder_if #(
   parameter int TAPS = 160,
   parameter int TS_W = 24
);
   logic [TAPS-1:0] therm_in;
   logic            hit;
   logic            ts_ready;
   logic            ts_valid;
   logic [TS_W-1:0] ts_data;
   logic            ts_flag;

   modport master (output therm_in, hit, ts_ready, input ts_valid, ts_data, ts_flag);
   modport slave  (input therm_in, hit, ts_ready, output ts_valid, ts_data, ts_flag);
endinterface

// File: rtl/tdc_ts_fifo.sv
// Timestamp FIFO: drops pushes when full unless a pop frees a slot in the same cycle.
module tdc_ts_fifo #(
   parameter int DW    = 25,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          ready,
   output logic          valid,
   output logic [DW-1:0] rdata,
   output logic [LW-1:0] level,
   output logic          drop
);
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          full, empty, pop, wr;

   assign empty = (level == '0);
   assign full  = (level == LW'(DEPTH));
   assign valid = !empty;
   assign pop   = valid && ready;
   assign wr    = push && (!full || pop);
   assign drop  = push && full && !pop;
   // Gated so the data port reads zero whenever nothing is held.
   assign rdata = empty ? '0 : mem[rp];

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (wr)  wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         level <= level + LW'(wr) - LW'(pop);
      end
   end
endmodule

// File: rtl/tdc_therm_encoder.sv
// TDC thermometer-to-timestamp encoder; define TDC_BUBBLE_FILTER_EN for the 3-tap majority filter.
module tdc_therm_encoder
   import tdc_pkg::*;
#(
   parameter int STAGES     = 40,
   parameter int COARSE_W   = 16,
   parameter int FIFO_DEPTH = 4,
   localparam int TAPS      = taps_of(STAGES),
   localparam int FINE_W    = fine_w(TAPS),
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   tdc_therm_encoder_if.slave   bus,
   input  logic                 clr_ovf,
   output logic                 overflow,
   output logic [LVL_W-1:0]     fifo_level
);
   typedef struct packed {
      logic [COARSE_W-1:0] coarse;
      logic [FINE_W-1:0]   fine;
      logic                flag;
   } entry_t;

   logic [COARSE_W-1:0] coarse, s1_coarse, s2_coarse;
   logic [TAPS-1:0]     s1_therm, s2_therm, filt;
   logic [1:0]          vld_pipe;
   logic [FINE_W-1:0]   fine;
   entry_t              push_ent, head;
   logic                drop;

`ifdef TDC_BUBBLE_FILTER_EN
   logic [TAPS-1:0] lo, hi;
   // Missing neighbours look like a settled thermometer: 1 below tap 0, 0 above the top.
   assign lo   = {s1_therm[TAPS-2:0], 1'b1};
   assign hi   = {1'b0, s1_therm[TAPS-1:1]};
   assign filt = (lo & s1_therm) | (lo & hi) | (s1_therm & hi);
`else
   assign filt = s1_therm;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         coarse    <= '0;
         vld_pipe  <= '0;
         s1_therm  <= '0;
         s1_coarse <= '0;
         s2_therm  <= '0;
         s2_coarse <= '0;
         overflow  <= 1'b0;
      end else begin
         coarse   <= coarse + 1'b1;
         vld_pipe <= {vld_pipe[0], bus.hit};
         if (bus.hit) begin
            s1_therm  <= bus.therm_in;
            s1_coarse <= coarse;
         end
         if (vld_pipe[0]) begin
            s2_therm  <= filt;
            s2_coarse <= s1_coarse;
         end
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   // Stage 3 is combinational into the FIFO write port.
   assign fine            = FINE_W'(popcount(MAX_TAPS'(s2_therm)));
   assign push_ent.coarse = s2_coarse;
   assign push_ent.fine   = fine;
   assign push_ent.flag   = (fine == '0) || (fine == FINE_W'(TAPS));

   tdc_ts_fifo #(.DW($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (vld_pipe[1]),
      .wdata (push_ent),
      .ready (bus.ts_ready),
      .valid (bus.ts_valid),
      .rdata (head),
      .level (fifo_level),
      .drop  (drop)
   );

   assign bus.ts_data = {head.coarse, head.fine};
   assign bus.ts_flag = head.flag;
endmodule

// File: tb/tb_tdc_therm_encoder.sv
// Directed bench for tdc_therm_encoder: vector table plus FIFO/overflow/wrap/reset sequences.
module tb_tdc_therm_encoder;
   import tdc_pkg::*;

   logic       clk, reset, clr_ovf, overflow;
   logic [2:0] fifo_level;
   int         n_chk, n_err, cyc;

   tdc_therm_encoder_if #(.TAPS(160), .TS_W(24)) bus ();

   tdc_therm_encoder dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .clr_ovf    (clr_ovf),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string        name;
      logic [159:0] therm;
      logic [7:0]   fine;
      logic         flag;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [159:0] ones(input int n);
      logic [159:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic do_reset();
      reset        = 1'b0;
      bus.hit      = 1'b0;
      bus.ts_ready = 1'b0;
      bus.therm_in = '0;
      clr_ovf      = 1'b0;
      step();
      step();
      reset = 1'b1;
      cyc   = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 64'(bus.ts_valid), 64'd0);
      check({tag, "_data"},  64'(bus.ts_data),  64'd0);
      check({tag, "_flag"},  64'(bus.ts_flag),  64'd0);
      check({tag, "_ovf"},   64'(overflow),     64'd0);
      check({tag, "_level"}, 64'(fifo_level),   64'd0);
   endtask

   vec_t         vecs[8];
   ts_t          exp_q[$];
   ts_t          e;
   int           hc;
   logic [15:0]  wrap_c[4];
   logic [7:0]   wrap_f[4];

   initial begin
      n_chk = 0; n_err = 0; cyc = 0;
      reset = 1'b0; clr_ovf = 1'b0;
      bus.hit = 1'b0; bus.ts_ready = 1'b0; bus.therm_in = '0;

      vecs[0] = '{"t37",    ones(37),  8'd37,  1'b0};
      vecs[1] = '{"zero",   '0,        8'd0,   1'b1};
      vecs[2] = '{"full",   ones(160), 8'd160, 1'b1};
      vecs[3] = '{"bub20",  ones(50),  8'd50,  1'b0};
      vecs[3].therm[20] = 1'b0;
      vecs[4] = '{"one",    ones(1),   8'd1,   1'b0};
      vecs[5] = '{"t159",   ones(159), 8'd159, 1'b0};
      vecs[6] = '{"spur",   ones(10),  8'd10,  1'b0};
      vecs[6].therm[100] = 1'b1;
      vecs[7] = '{"t4",     ones(4),   8'd4,   1'b0};
`ifndef TDC_BUBBLE_FILTER_EN
      vecs[3].fine = 8'd49;
      vecs[6].fine = 8'd11;
`endif

      #2;
      check_zero("rst");

      // First hit at cycle 10, valid exactly 3 cycles later, held while not ready
      do_reset();
      repeat (10) step();
      bus.therm_in = ones(37); bus.hit = 1'b1;
      step();
      bus.hit = 1'b0;
      step();
      check("lat_early_valid", 64'(bus.ts_valid), 64'd0);
      step();
      check("lat_valid", 64'(bus.ts_valid), 64'd1);
      check("lat_data",  64'(bus.ts_data),  64'h000A25);
      check("lat_flag",  64'(bus.ts_flag),  64'd0);
      step();
      check("hold_data",  64'(bus.ts_data), 64'h000A25);
      check("hold_level", 64'(fifo_level),  64'd1);
      bus.ts_ready = 1'b1;
      step();
      check("hold_pop", 64'(bus.ts_valid), 64'd0);

      // Vector table, one isolated hit each, consumer always ready
      for (int k = 0; k < 8; k++) begin
         bus.therm_in = vecs[k].therm; bus.hit = 1'b1; hc = cyc;
         step();
         bus.hit = 1'b0;
         step();
         check({vecs[k].name, "_nobypass"}, 64'(bus.ts_valid), 64'd0);
         step();
         check({vecs[k].name, "_valid"}, 64'(bus.ts_valid), 64'd1);
         check({vecs[k].name, "_data"},  64'(bus.ts_data),  64'({16'(hc), vecs[k].fine}));
         check({vecs[k].name, "_flag"},  64'(bus.ts_flag),  64'(vecs[k].flag));
         step();
         check({vecs[k].name, "_popped"}, 64'(bus.ts_valid), 64'd0);
      end

      // Six back-to-back hits into a stalled FIFO: first four kept, overflow sticky
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         bus.therm_in = ones(i + 1); bus.hit = 1'b1;
         if (i < 4) begin
            e.coarse = 16'(cyc); e.fine = 8'(i + 1); e.flag = 1'b0;
            exp_q.push_back(e);
         end
         step();
      end
      bus.hit = 1'b0;
      repeat (3) step();
      check("ovf_level", 64'(fifo_level), 64'd4);
      check("ovf_set",   64'(overflow),   64'd1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check("ovf_clr", 64'(overflow), 64'd0);
      // Drop coinciding with clr_ovf: the set must win
      bus.therm_in = ones(99); bus.hit = 1'b1;
      step();
      bus.hit = 1'b0;
      step();
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check("ovf_set_wins", 64'(overflow), 64'd1);
      bus.ts_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("order_valid", 64'(bus.ts_valid), 64'd1);
         check("order_data",  64'({bus.ts_data, bus.ts_flag}), 64'(exp_q[i]));
         step();
      end
      check("order_empty", 64'(fifo_level), 64'd0);

      // Coarse wrap across consecutive hits, then push+pop while full
      do_reset();
      while (cyc != 65533) step();
      for (int i = 0; i < 4; i++) begin
         bus.therm_in = ones(10 + i); bus.hit = 1'b1;
         step();
      end
      bus.hit = 1'b0;
      step();
      step();
      check("wrap_level", 64'(fifo_level), 64'd4);
      bus.therm_in = ones(20); bus.hit = 1'b1;
      step();
      bus.hit = 1'b0;
      step();
      bus.ts_ready = 1'b1;
      step();
      bus.ts_ready = 1'b0;
      check("fullpp_level", 64'(fifo_level), 64'd4);
      check("fullpp_ovf",   64'(overflow),   64'd0);
      wrap_c = '{16'd65534, 16'd65535, 16'd0, 16'd3};
      wrap_f = '{8'd11, 8'd12, 8'd13, 8'd20};
      bus.ts_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("wrap_data", 64'(bus.ts_data), 64'({wrap_c[i], wrap_f[i]}));
         step();
      end
      check("wrap_empty", 64'(bus.ts_valid), 64'd0);

      // Reset one cycle after a hit with data already queued: everything discarded
      do_reset();
      bus.therm_in = ones(5); bus.hit = 1'b1;
      step();
      bus.hit = 1'b0;
      step();
      step();
      check("mid_pre_valid", 64'(bus.ts_valid), 64'd1);
      bus.therm_in = ones(7); bus.hit = 1'b1;
      step();
      bus.hit = 1'b0;
      reset = 1'b0;
      #1;
      check_zero("mid_rst");
      step();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("mid_no_valid", 64'(bus.ts_valid), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
